// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link: default duty-code width and the
// capture FSM state encoding, also used by loopback benches.
package pwm_pkg;

    localparam int PWM_DUTY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider producing floor(num*2^DUTY_W/den), one
// quotient bit per clock, MSB first; saturates when num >= den.
module pwm_div
    import pwm_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = PWM_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic [DUTY_W-1:0] q,
    output logic              done
);

    localparam int IT_W = $clog2(DUTY_W + 1);
    localparam logic [IT_W-1:0] LAST = IT_W'(DUTY_W - 1);

    logic              busy_q, busy_d;
    logic [IT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic [CNT_W-1:0]  den_q, den_d;
    logic [DUTY_W-1:0] quo_q, quo_d;
    logic              sat_q, sat_d;

    logic [CNT_W:0]    rem_sh;
    logic [CNT_W:0]    rem_nx;
    logic [DUTY_W-1:0] quo_nx;
    logic              ge;

    always_comb begin
        rem_sh = rem_q << 1;
        ge     = rem_sh >= {1'b0, den_q};
        rem_nx = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
        quo_nx = {quo_q[DUTY_W-2:0], ge};
        done   = busy_q && (cnt_q == LAST);
        // q is only meaningful in the done cycle: it carries the final bit
        q      = sat_q ? {DUTY_W{1'b1}} : quo_nx;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        den_d  = den_q;
        quo_d  = quo_q;
        sat_d  = sat_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = {1'b0, num};
            den_d  = den;
            quo_d  = '0;
            sat_d  = (num >= den);
        end else if (busy_q) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + IT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            quo_q  <= quo_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between rising edges of an
// asynchronous input and reports an 8-bit duty code via pwm_div.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = PWM_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              timeout,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              s_prev_q, s_prev_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_time_q, high_time_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    logic              s;
    logic              rise;
    logic              tmo_evt;
    logic              div_start;
    logic              div_done;
    logic [DUTY_W-1:0] div_q;

    pwm_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (hi_cnt_q),
        .den   (per_cnt_q),
        .q     (div_q),
        .done  (div_done)
    );

    always_comb begin
        sync1_d  = pwm_in;
        sync2_d  = sync1_q;
        s        = sync2_q;
        s_prev_d = s;
        rise     = s & ~s_prev_q;

        if (rise) begin
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
        end else begin
            per_cnt_d = sat_inc(per_cnt_q);
            hi_cnt_d  = s ? sat_inc(hi_cnt_q) : hi_cnt_q;
        end

        // Fires only on the step into saturation, so a stuck input reports once
        tmo_evt = !rise && (state_q != ST_DIVIDE) && (per_cnt_q == CNT_PRE);

        state_d     = state_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        overrun_d   = 1'b0;
        div_start   = 1'b0;

        case (state_q)
            ST_IDLE, ST_MEASURE: begin
                if (rise) begin
                    if (state_q == ST_MEASURE) begin
                        period_d    = per_cnt_q;
                        high_time_d = hi_cnt_q;
                        div_start   = 1'b1;
                        state_d     = ST_DIVIDE;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else if (tmo_evt) begin
                    period_d    = '0;
                    high_time_d = '0;
                    duty_d      = {DUTY_W{s}};
                    valid_d     = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (rise) begin
                    overrun_d = 1'b1;
                end
                if (div_done) begin
                    duty_d    = div_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = ST_MEASURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            s_prev_q    <= 1'b0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            period_q    <= '0;
            high_time_q <= '0;
            duty_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            s_prev_q    <= s_prev_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            state_q     <= state_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign duty      = duty_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;

endmodule
